// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, segment bit positions and scan FSM states
// Contents: SEG_A..SEG_DP bit indices into the 8-bit seg bus, SEG_PAT active-high
//   a..g patterns for hex 0-F (bit 6 = a ... bit 0 = g), state_t scan FSM states.
package seg7_pkg;
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;
   localparam logic [6:0] SEG_PAT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };
   typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to active-high a..g pattern
// Ports: nib (4-bit hex digit in), pat (7-bit pattern out, bit 6 = a ... bit 0 = g).
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);
   always_comb pat = SEG_PAT[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment scan driver with dead-time
// Ports: clk; rst_n synchronous active-low; load strobes value/dp_in into the pending
//   register; en_mask is a live per-digit enable; seg {a..g,dp} and an are registered
//   pin drives; frame_done pulses on the final cycle of the last slot; update_pending
//   is high while a loaded value waits for the frame boundary.
// Build option: define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int SLOT_CYCLES    = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_mask,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done,
   output logic                  update_pending
);
   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] DIG_LAST = IW'(DIGITS - 1);
   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic                  slot_end, wrap;
   logic [4*DIGITS-1:0]   pend_val, disp_val;
   logic [DIGITS-1:0]     pend_dp, disp_dp;
   logic [DIGITS-1:0]     vis;
   logic [3:0]            nib;
   logic [6:0]            pat;
   logic                  cur_en, cur_dp, seg_on, an_on;
   logic [7:0]            seg_hi, seg_nxt;
   logic [DIGITS-1:0]     an_sel, an_nxt;

   always_comb begin
      slot_end  = cnt == SLOT_LAST;
      wrap      = slot_end && idx == DIG_LAST;
      cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
      idx_nxt   = wrap ? '0 : slot_end ? idx + 1'b1 : idx;
      state_nxt = (state == BLANK && cnt == BLANK_LAST) ? SHOW :
                  (state == SHOW && slot_end) ? BLANK : state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   assign frame_done = wrap;

`ifdef SEG7_LZ_BLANK_EN
   logic nz;
   // Scan from the top digit down: a digit is visible once any nibble at or above it is nonzero.
   always_comb begin
      nz  = 1'b0;
      vis = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz     = nz | (disp_val[i*4 +: 4] != 4'h0);
         vis[i] = nz;
      end
      vis[0] = 1'b1;
   end
`else
   always_comb vis = '1;
`endif

   assign nib = disp_val[idx*4 +: 4];

   seg7_hex_decoder u_dec (
      .nib (nib),
      .pat (pat)
   );

   // A blanked digit with its dp set keeps its anode on so the dp alone is shown.
   always_comb begin
      cur_en = en_mask[idx] && state == SHOW;
      cur_dp = disp_dp[idx];
      seg_on = cur_en & vis[idx];
      an_on  = seg_on | (cur_en & cur_dp);
      seg_hi = '0;
      seg_hi[SEG_A]  = seg_on & pat[6];
      seg_hi[SEG_B]  = seg_on & pat[5];
      seg_hi[SEG_C]  = seg_on & pat[4];
      seg_hi[SEG_D]  = seg_on & pat[3];
      seg_hi[SEG_E]  = seg_on & pat[2];
      seg_hi[SEG_F]  = seg_on & pat[1];
      seg_hi[SEG_G]  = seg_on & pat[0];
      seg_hi[SEG_DP] = an_on & cur_dp;
      seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      an_sel  = an_on ? DIGITS'(1) << idx : '0;
      an_nxt  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
   end

   // The boundary copy reads pending before this cycle's load overwrites it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_val       <= '0;
         pend_dp        <= '0;
         disp_val       <= '0;
         disp_dp        <= '0;
         update_pending <= 1'b0;
         seg            <= SEG_OFF;
         an             <= AN_OFF;
      end else begin
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (wrap && update_pending) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         update_pending <= load | (update_pending & ~wrap);
         seg            <= seg_nxt;
         an             <= an_nxt;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank)
module tb_seg7_scan_driver;
   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      int         gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  en_mask;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_done;
   logic        update_pending;

   int   vectors = 0;
   int   fails = 0;
   exp_t q[$];

   // active-low seg codes for hex 0-F with dp off
   logic [7:0] code [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

`ifdef SEG7_LZ_BLANK_EN
   localparam logic [3:0] EN_ZERO = 4'b0001;
   localparam logic [3:0] EN_0050 = 4'b0011;
`else
   localparam logic [3:0] EN_ZERO = 4'b1111;
   localparam logic [3:0] EN_0050 = 4'b1111;
`endif

   seg7_scan_driver #(
      .DIGITS         (4),
      .SLOT_CYCLES    (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load           (load),
      .value          (value),
      .dp_in          (dp_in),
      .en_mask        (en_mask),
      .seg            (seg),
      .an             (an),
      .frame_done     (frame_done),
      .update_pending (update_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                             input bit first);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            e.an  = ~(4'b0001 << i);
            e.seg = code[v[i*4 +: 4]] & ~{7'b0, dp[i]};
            e.gap = (en[(i + 3) % 4] && !(i == 0 && first)) ? 2 : 0;
            q.push_back(e);
         end
      end
   endtask

   task automatic next_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 100);
      if (!frame_done) begin
         vectors++;
         fails++;
         $display("FAIL frame_timeout: got no frame_done within %0d cycles", n);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      load  = 1'b1;
      value = v;
      dp_in = dp;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // monitor: pops one expectation at the start of each lit window
   int         gap_cnt = 0, win_len = 0, cyc = 0, last_fd = -1;
   bit         in_win = 0;
   logic [3:0] win_an;
   logic [7:0] win_seg;
   exp_t       m;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_win  = 0;
         gap_cnt = 0;
         last_fd = -1;
      end else begin
         if (an != 4'hF) begin
            if (!in_win) begin
               vectors++;
               if (q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_window: got an=%b seg=%h expected no lit digit", an, seg);
               end else begin
                  m = q.pop_front();
                  if (an !== m.an || seg !== m.seg) begin
                     fails++;
                     $display("FAIL window: got an=%b seg=%h expected an=%b seg=%h", an, seg, m.an, m.seg);
                  end
                  if (m.gap != 0) begin
                     vectors++;
                     if (gap_cnt != m.gap) begin
                        fails++;
                        $display("FAIL dead_time: got %0d blank cycles expected %0d", gap_cnt, m.gap);
                     end
                  end
               end
               in_win  = 1;
               win_len = 1;
               win_an  = an;
               win_seg = seg;
            end else begin
               win_len++;
               vectors++;
               if (an !== win_an || seg !== win_seg) begin
                  fails++;
                  $display("FAIL window_stable: got an=%b seg=%h expected an=%b seg=%h", an, seg, win_an, win_seg);
               end
            end
         end else begin
            if (in_win) begin
               vectors++;
               if (win_len != 6) begin
                  fails++;
                  $display("FAIL show_len: got %0d cycles expected 6", win_len);
               end
               in_win  = 0;
               gap_cnt = 0;
            end
            gap_cnt++;
         end
         if (frame_done) begin
            if (last_fd >= 0) begin
               vectors++;
               if (cyc - last_fd != 32) begin
                  fails++;
                  $display("FAIL frame_period: got %0d cycles expected 32", cyc - last_fd);
               end
            end
            last_fd = cyc;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000ns");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      value   = '0;
      dp_in   = '0;
      en_mask = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst_seg", {24'b0, seg}, 32'hFF);
      chk("rst_an", {28'b0, an}, 32'hF);
      chk("rst_frame_done", {31'b0, frame_done}, 32'h0);
      chk("rst_upd", {31'b0, update_pending}, 32'h0);
      push_frame(16'h0000, 4'h0, EN_ZERO, 1'b1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("show_before_rst", {28'b0, an}, 32'hE);
      rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      chk("mid_rst_seg", {24'b0, seg}, 32'hFF);
      chk("mid_rst_an", {28'b0, an}, 32'hF);
      chk("mid_rst_frame_done", {31'b0, frame_done}, 32'h0);
      chk("mid_rst_upd", {31'b0, update_pending}, 32'h0);
      @(negedge clk);
      push_frame(16'h0000, 4'h0, EN_ZERO, 1'b1);
      rst_n = 1'b1;

      next_frame();
      push_frame(16'h0000, 4'h0, EN_ZERO, 1'b0);
      repeat (5) @(negedge clk);
      do_load(16'h12AF, 4'h0);
      chk("upd_set", {31'b0, update_pending}, 32'h1);

      next_frame();
      chk("upd_hold_at_fd", {31'b0, update_pending}, 32'h1);
      push_frame(16'h12AF, 4'h0, 4'hF, 1'b0);
      @(negedge clk);
      chk("upd_clear", {31'b0, update_pending}, 32'h0);
      repeat (3) @(negedge clk);
      do_load(16'h1111, 4'h0);
      repeat (3) @(negedge clk);
      do_load(16'h2222, 4'b0010);

      next_frame();
      push_frame(16'h2222, 4'b0010, 4'b1011, 1'b0);
      repeat (5) @(negedge clk);
      en_mask = 4'b1011;
      repeat (5) @(negedge clk);
      do_load(16'h3456, 4'h0);

      next_frame();
      push_frame(16'h3456, 4'h0, 4'hF, 1'b0);
      do_load(16'h789B, 4'b0001);
      chk("upd_coincident", {31'b0, update_pending}, 32'h1);
      repeat (4) @(negedge clk);
      en_mask = 4'hF;

      next_frame();
      push_frame(16'h789B, 4'b0001, 4'hF, 1'b0);
      @(negedge clk);
      chk("upd_clear2", {31'b0, update_pending}, 32'h0);
      repeat (4) @(negedge clk);
      do_load(16'h0050, 4'h0);

      next_frame();
      push_frame(16'h0050, 4'h0, EN_0050, 1'b0);
      repeat (5) @(negedge clk);
      do_load(16'h0000, 4'h0);

      next_frame();
      push_frame(16'h0000, 4'h0, EN_ZERO, 1'b0);

      next_frame();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
